// File: rtl/fiber_tx_sched.sv
// rtl/fiber_tx_sched.sv - frame-slot payload scheduler and cadence watchdog for the fiber uplink
module fiber_tx_sched #(
    parameter int DW        = 12,
    parameter int MAX_HI    = 4,
    parameter int STALL_CYC = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          req_flt,
    input  logic [DW-1:0] dat_flt,
    input  logic          req_a,
    input  logic [DW-1:0] dat_a,
    input  logic          req_b,
    input  logic [DW-1:0] dat_b,
    output logic          gnt_flt,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic [DW-1:0] tx_data,
    output logic [1:0]    tx_tag,
    output logic          tx_valid,
    output logic          link_stall
);

    localparam int HW = $clog2(MAX_HI + 1);
    localparam int WW = $clog2(STALL_CYC + 1);

    localparam logic [1:0] TAG_IDLE = 2'b00;
    localparam logic [1:0] TAG_FLT  = 2'b01;
    localparam logic [1:0] TAG_A    = 2'b10;
    localparam logic [1:0] TAG_B    = 2'b11;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    logic [HW-1:0] hi_cnt_q, hi_cnt_d;
    logic          rr_last_q, rr_last_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          link_stall_q, link_stall_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic [1:0]    tx_tag_q, tx_tag_d;
    logic          gnt_flt_q, gnt_flt_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;

    logic [1:0]    sel;
    logic          flt_ok;
    logic          ab_req;

    assign flt_ok = req_flt && (hi_cnt_q < HW'(MAX_HI));
    assign ab_req = req_a || req_b;

    // Winner selection; only consulted in the frame_tick cycle
    always_comb begin
        sel       = TAG_IDLE;
        hi_cnt_d  = hi_cnt_q;
        rr_last_d = rr_last_q;
        if (frame_tick) begin
            if (flt_ok) begin
                sel      = TAG_FLT;
                hi_cnt_d = ab_req ? hi_cnt_q + HW'(1) : '0;
            end else if (ab_req) begin
                if (rr_last_q == RR_B) begin
                    sel = req_a ? TAG_A : TAG_B;
                end else begin
                    sel = req_b ? TAG_B : TAG_A;
                end
                rr_last_d = (sel == TAG_B) ? RR_B : RR_A;
                hi_cnt_d  = '0;
            end else if (req_flt) begin
                sel = TAG_FLT;
            end
        end
    end

    always_comb begin
        tx_tag_d  = tx_tag_q;
        tx_data_d = tx_data_q;
        if (frame_tick) begin
            tx_tag_d = sel;
            case (sel)
                TAG_FLT: tx_data_d = dat_flt;
                TAG_A:   tx_data_d = dat_a;
                TAG_B:   tx_data_d = dat_b;
                default: tx_data_d = '0;
            endcase
        end
        gnt_flt_d = frame_tick && (sel == TAG_FLT);
        gnt_a_d   = frame_tick && (sel == TAG_A);
        gnt_b_d   = frame_tick && (sel == TAG_B);
    end

    // Cadence watchdog: stall is sticky until the transmitter ticks again
    always_comb begin
        wd_cnt_d     = wd_cnt_q;
        link_stall_d = link_stall_q;
        if (frame_tick) begin
            wd_cnt_d     = '0;
            link_stall_d = 1'b0;
        end else begin
            if (wd_cnt_q != WW'(STALL_CYC)) begin
                wd_cnt_d = wd_cnt_q + WW'(1);
            end
            if (wd_cnt_q == WW'(STALL_CYC - 1)) begin
                link_stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_q     <= '0;
            rr_last_q    <= RR_B;
            wd_cnt_q     <= '0;
            link_stall_q <= 1'b0;
            tx_data_q    <= '0;
            tx_tag_q     <= TAG_IDLE;
            gnt_flt_q    <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
        end else begin
            hi_cnt_q     <= hi_cnt_d;
            rr_last_q    <= rr_last_d;
            wd_cnt_q     <= wd_cnt_d;
            link_stall_q <= link_stall_d;
            tx_data_q    <= tx_data_d;
            tx_tag_q     <= tx_tag_d;
            gnt_flt_q    <= gnt_flt_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
        end
    end

    assign gnt_flt    = gnt_flt_q;
    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign tx_data    = tx_data_q;
    assign tx_tag     = tx_tag_q;
    assign tx_valid   = (tx_tag_q != TAG_IDLE);
    assign link_stall = link_stall_q;

endmodule

// File: tb/tb_fiber_tx_sched.sv
// tb/tb_fiber_tx_sched.sv - scoreboard bench for fiber_tx_sched against a frame-level model
module tb_fiber_tx_sched;

    localparam int DW        = 12;
    localparam int MAX_HI    = 4;
    localparam int STALL_CYC = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_tick;
    logic          req_flt, req_a, req_b;
    logic [DW-1:0] dat_flt, dat_a, dat_b;
    logic          gnt_flt, gnt_a, gnt_b;
    logic [DW-1:0] tx_data;
    logic [1:0]    tx_tag;
    logic          tx_valid;
    logic          link_stall;

    fiber_tx_sched #(.DW(DW), .MAX_HI(MAX_HI), .STALL_CYC(STALL_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .req_flt    (req_flt),
        .dat_flt    (dat_flt),
        .req_a      (req_a),
        .dat_a      (dat_a),
        .req_b      (req_b),
        .dat_b      (dat_b),
        .gnt_flt    (gnt_flt),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .tx_data    (tx_data),
        .tx_tag     (tx_tag),
        .tx_valid   (tx_valid),
        .link_stall (link_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Frame-level model state: fault streak length and last served a/b channel
    int   streak;
    bit   last_was_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input bit rf, input bit ra, input bit rb,
                                   input logic [DW-1:0] df, input logic [DW-1:0] da,
                                   input logic [DW-1:0] db);
        exp_t e;
        e.tag  = 2'b00;
        e.data = '0;
        if (rf && streak < MAX_HI) begin
            e.tag  = 2'b01;
            e.data = df;
            streak = (ra || rb) ? streak + 1 : 0;
        end else if (ra || rb) begin
            bit pick_b;
            if (ra && rb) pick_b = !last_was_b;
            else          pick_b = rb;
            e.tag      = pick_b ? 2'b11 : 2'b10;
            e.data     = pick_b ? db : da;
            last_was_b = pick_b;
            streak     = 0;
        end else if (rf) begin
            e.tag  = 2'b01;
            e.data = df;
        end
        return e;
    endfunction

    task automatic do_tick(input bit rf, input bit ra, input bit rb,
                           input logic [DW-1:0] df, input logic [DW-1:0] da,
                           input logic [DW-1:0] db);
        @(posedge clk);
        #1;
        req_flt    = rf;
        req_a      = ra;
        req_b      = rb;
        dat_flt    = df;
        dat_a      = da;
        dat_b      = db;
        frame_tick = 1'b1;
        sb.push_back(model(rf, ra, rb, df, da, db));
    endtask

    task automatic rand_tick();
        do_tick(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    task automatic gap(input int n, input bit scramble);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            if (scramble) begin
                req_flt = 1'($urandom);
                req_a   = 1'($urandom);
                req_b   = 1'($urandom);
                dat_flt = DW'($urandom);
                dat_a   = DW'($urandom);
                dat_b   = DW'($urandom);
            end
        end
    endtask

    // Monitor: edge bookkeeping for the watchdog, then checks away from the edge
    longint edge_cnt = 0;
    longint last_evt = 0;
    bit     tick_seen = 1'b0;

    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n || frame_tick) last_evt = edge_cnt;
        tick_seen = frame_tick && rst_n;
    end

    logic [1:0]    exp_tag  = 2'b00;
    logic [DW-1:0] exp_data = '0;

    always @(negedge clk) begin
        logic [2:0] exp_gnt;
        exp_t       e;
        if (!rst_n) begin
            sb.delete();
            exp_tag  = 2'b00;
            exp_data = '0;
        end else begin
            exp_gnt = 3'b000;
            if (tick_seen) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    e        = sb.pop_front();
                    exp_tag  = e.tag;
                    exp_data = e.data;
                    exp_gnt  = {exp_tag == 2'b01, exp_tag == 2'b10, exp_tag == 2'b11};
                end
            end
            chk("tx_tag", 32'(tx_tag), 32'(exp_tag));
            chk("tx_data", 32'(tx_data), 32'(exp_data));
            chk("tx_valid", 32'(tx_valid), 32'(exp_tag != 2'b00));
            chk("gnt_flt_a_b", 32'({gnt_flt, gnt_a, gnt_b}), 32'(exp_gnt));
            chk("link_stall", 32'(link_stall), 32'((edge_cnt - last_evt) >= STALL_CYC));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        req_flt    = 1'b0;
        req_a      = 1'b0;
        req_b      = 1'b0;
        dat_flt    = '0;
        dat_a      = '0;
        dat_b      = '0;
        streak     = 0;
        last_was_b = 1'b1;
        #1;
        chk("reset_tag", 32'(tx_tag), 32'd0);
        chk("reset_stall", 32'(link_stall), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle frame after reset
        do_tick(0, 0, 0, 12'h123, 12'h456, 12'h789);
        gap(3, 0);

        // Round robin between A and B
        for (int i = 0; i < 4; i++) begin
            do_tick(0, 1, 1, 12'h000, 12'h0A5, 12'h35A);
            gap(2, 0);
        end

        // Fault cap with all channels requesting
        for (int i = 0; i < 6; i++) begin
            do_tick(1, 1, 1, 12'h7E1, 12'h0A5, 12'h35A);
            gap(2, 0);
        end

        // Fault channel alone
        for (int i = 0; i < 6; i++) begin
            do_tick(1, 0, 0, 12'hFFF, 12'h000, 12'h000);
            gap(1, 0);
        end

        // Request raised one clock after the tick waits for the next frame
        do_tick(0, 0, 0, 12'h000, 12'h111, 12'h000);
        gap(1, 0);
        req_a = 1'b1;
        gap(2, 0);
        do_tick(0, 1, 0, 12'h000, 12'h222, 12'h000);
        gap(2, 0);

        // Back-to-back ticks
        for (int i = 0; i < 4; i++) rand_tick();
        gap(2, 0);

        // Stall: no ticks for longer than the watchdog window
        rand_tick();
        gap(STALL_CYC + 100, 1);
        rand_tick();
        gap(3, 0);

        for (int i = 0; i < 300; i++) begin
            rand_tick();
            gap($urandom_range(0, 12), 1);
        end

        // Asynchronous reset mid-frame, with a live request pending across it
        do_tick(0, 1, 0, 12'h000, 12'hABC, 12'h000);
        gap(4, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tag", 32'(tx_tag), 32'd0);
        chk("async_rst_data", 32'(tx_data), 32'd0);
        chk("async_rst_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_gnt", 32'({gnt_flt, gnt_a, gnt_b}), 32'd0);
        chk("async_rst_stall", 32'(link_stall), 32'd0);
        streak     = 0;
        last_was_b = 1'b1;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gap(2, 0);
        do_tick(0, 0, 0, 12'h000, 12'h000, 12'h000);
        gap(2, 0);
        do_tick(0, 1, 1, 12'h000, 12'h5A5, 12'hA5A);
        gap(2, 0);

        for (int i = 0; i < 40; i++) begin
            rand_tick();
            gap($urandom_range(0, 5), 1);
        end
        gap(5, 0);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
